// File: rtl/dataflow_source_fifo.sv
// Host-filled FIFO that answers the dataflow graph's req/ack pull handshake.
// Optional stall counter is built only when DATAFLOW_SRC_STALL_CNT_EN is defined.
module dataflow_source_fifo #(
  parameter int data_width = 32,
  parameter int depth_log2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [data_width-1:0] wr_data,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [31:0]           count,
  output logic [depth_log2:0]   level,
  output logic [31:0]           stall_count
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] full_level = (depth_log2 + 1)'(depth);

  logic [data_width-1:0] mem [depth];
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  // No bypass: a full FIFO refuses writes even on an edge that also pops.
  assign wr_ready = (level < full_level);
  assign push     = wr_valid & wr_ready;
  assign pop      = req & ~ack & (level != '0);

  // NOTE: storage has no reset; the pointers and level define what is valid,
  // so clearing the array would only cost a reset net to every word.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes "pop uses old level" hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ack    <= 1'b0;
      dout   <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        ack    <= 1'b1;
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count + 32'd1;
      end else begin
        ack    <= 1'b0;
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

`ifdef DATAFLOW_SRC_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (req && !ack && (level == '0)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_dataflow_source_fifo.sv
// Directed bench for dataflow_source_fifo: vector table plus stall and
// reset-after-ack sequences, run on a 4-deep instance.
module tb_dataflow_source_fifo;

  localparam int dw = 32;
  localparam int dl = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [dw-1:0] wr_data;
  logic          req;
  logic          ack;
  logic [dw-1:0] dout;
  logic [31:0]   count;
  logic [dl:0]   level;
  logic [31:0]   stall_count;

  int errors = 0;
  int checks = 0;

  dataflow_source_fifo #(.data_width(dw), .depth_log2(dl)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .req(req), .ack(ack), .dout(dout), .count(count),
    .level(level), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wv;
    logic [31:0] wd;
    logic        req;
    logic        ack;
    logic [31:0] dout;
    logic [31:0] level;
    logic [31:0] count;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic wv, input logic [31:0] wd,
                     input logic rq, input logic a, input logic [31:0] d,
                     input logic [31:0] l, input logic [31:0] c, input logic rdy);
    vec_t v;
    v.rst = r; v.wv = wv; v.wd = wd; v.req = rq;
    v.ack = a; v.dout = d; v.level = l; v.count = c; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_stall;
  logic [31:0] exp_stall_after;

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; req = 1'b0;

    //   rst wv data   req  ack dout lvl cnt rdy
    add(0, 0, 0,     0,   0, 0,  0, 0, 1);
    add(0, 0, 0,     0,   0, 0,  0, 0, 1);
    add(1, 1, 5,     0,   0, 0,  1, 0, 1);
    add(1, 1, 6,     0,   0, 0,  2, 0, 1);
    add(1, 1, 7,     0,   0, 0,  3, 0, 1);
    add(1, 0, 0,     1,   1, 5,  2, 1, 1);
    add(1, 0, 0,     1,   0, 5,  2, 1, 1);
    add(1, 0, 0,     1,   1, 6,  1, 2, 1);
    add(1, 0, 0,     1,   0, 6,  1, 2, 1);
    add(1, 0, 0,     1,   1, 7,  0, 3, 1);
    add(1, 0, 0,     1,   0, 7,  0, 3, 1);
    add(1, 0, 0,     0,   0, 7,  0, 3, 1);
    // fill to full, then a refused fifth write
    add(1, 1, 10,    0,   0, 7,  1, 3, 1);
    add(1, 1, 11,    0,   0, 7,  2, 3, 1);
    add(1, 1, 12,    0,   0, 7,  3, 3, 1);
    add(1, 1, 13,    0,   0, 7,  4, 3, 0);
    add(1, 1, 14,    0,   0, 7,  4, 3, 0);
    // pop while full with write still offered: write refused
    add(1, 1, 14,    1,   1, 10, 3, 4, 1);
    add(1, 0, 0,     0,   0, 10, 3, 4, 1);
    add(1, 0, 0,     1,   1, 11, 2, 5, 1);
    add(1, 0, 0,     0,   0, 11, 2, 5, 1);
    // simultaneous write and pop at level 2
    add(1, 1, 20,    1,   1, 12, 2, 6, 1);
    add(1, 0, 0,     0,   0, 12, 2, 6, 1);
    add(1, 0, 0,     1,   1, 13, 1, 7, 1);
    add(1, 0, 0,     0,   0, 13, 1, 7, 1);
    add(1, 0, 0,     1,   1, 20, 0, 8, 1);
    add(1, 0, 0,     0,   0, 20, 0, 8, 1);
    // request on empty: nothing happens
    add(1, 0, 0,     1,   0, 20, 0, 8, 1);
    add(1, 0, 0,     1,   0, 20, 0, 8, 1);
    add(1, 0, 0,     0,   0, 20, 0, 8, 1);

    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; wr_valid = vecs[i].wv; wr_data = vecs[i].wd; req = vecs[i].req;
      step();
      check($sformatf("v%0d ack", i),      32'(ack),      32'(vecs[i].ack));
      check($sformatf("v%0d dout", i),     dout,          vecs[i].dout);
      check($sformatf("v%0d level", i),    32'(level),    vecs[i].level);
      check($sformatf("v%0d count", i),    count,         vecs[i].count);
      check($sformatf("v%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].rdy));
    end

`ifdef DATAFLOW_SRC_STALL_CNT_EN
    exp_stall = 32'd10;
    exp_stall_after = 32'd11;
`else
    exp_stall = 32'd0;
    exp_stall_after = 32'd0;
`endif

    // Stall sequence: req held on an empty FIFO, then a late write.
    rst = 1'b0; wr_valid = 1'b0; req = 1'b0;
    step();
    check("stall reset", stall_count, 32'd0);
    rst = 1'b1; req = 1'b1;
    repeat (10) step();
    check("stall count 10", stall_count, exp_stall);
    check("stall ack idle", 32'(ack), 32'd0);
    check("stall level", 32'(level), 32'd0);
    wr_valid = 1'b1; wr_data = 32'h0000_ABCD;
    step();
    wr_valid = 1'b0;
    check("stall write edge ack", 32'(ack), 32'd0);
    check("stall write level", 32'(level), 32'd1);
    check("stall write edge count", stall_count, exp_stall_after);
    step();
    check("stall late ack", 32'(ack), 32'd1);
    check("stall late dout", dout, 32'h0000_ABCD);
    check("stall late count", count, 32'd1);
    check("stall after ack", stall_count, exp_stall_after);
    req = 1'b0;
    step();

    // Reset right after an ack with three words still queued.
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_data = 32'(i + 1);
      step();
    end
    wr_valid = 1'b0;
    check("rst-seq full", 32'(level), 32'd4);
    req = 1'b1;
    step();
    check("rst-seq ack", 32'(ack), 32'd1);
    check("rst-seq dout", dout, 32'd1);
    check("rst-seq level", 32'(level), 32'd3);
    rst = 1'b0;
    step();
    check("rst-seq ack cleared", 32'(ack), 32'd0);
    check("rst-seq level cleared", 32'(level), 32'd0);
    check("rst-seq count cleared", count, 32'd0);
    check("rst-seq dout cleared", dout, 32'd0);
    check("rst-seq stall cleared", stall_count, 32'd0);
    check("rst-seq wr_ready", 32'(wr_ready), 32'd1);
    rst = 1'b1;
    repeat (3) begin
      step();
      check("rst-seq no stale ack", 32'(ack), 32'd0);
      check("rst-seq stays empty", 32'(level), 32'd0);
    end
    req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dataflow_source_fifo.md
# dataflow_source_fifo

Synthesizable req/ack responder that feeds an input node of the dataflow graph `G`. A host-side valid/ready write port fills a FIFO. The graph's `in` operator pulls words through the same req/ack handshake that the graph's operators use. This replaces the behavioural `producer` model in hardware builds: the graph is the initiator and this block is the responder.

## Interface
Parameters:
- `data_width`, 32, word width.
- `depth_log2`, 4, FIFO depth is 2^depth_log2 words.

Ports:
- `clk`  in  1  sole clock; all logic updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low: reset when `rst`=0 at a rising edge.
- `wr_valid`  in  1  host word present.
- `wr_ready`  out  1  FIFO can accept a word.
- `wr_data`  in  data_width  host word.
- `req`  in  1  request from the graph `in` operator.
- `ack`  out  1  registered one-cycle acknowledge pulse.
- `dout`  out  data_width  registered word delivered with `ack`.
- `count`  out  32  number of words delivered.
- `level`  out  depth_log2+1  current FIFO occupancy.
- `stall_count`  out  32  cycles in which `req` was pending and the FIFO was empty (see Configuration).

## Operation
- Storage:
  - Circular buffer of 2^depth_log2 entries.
  - Read and write pointers are depth_log2 bits wide and wrap modulo depth.
  - `level` is a separate counter, 0..2^depth_log2.
- Write side:
  - `wr_ready` = (`level` < 2^depth_log2), combinational from `level` only.
  - A write occurs on an edge where `wr_valid` & `wr_ready`: `wr_data` is stored at the write pointer, and the write pointer advances.
- Read side, evaluated at each rising edge:
  - If `req` & ~`ack` & (`level` != 0):
    - `ack` <= 1.
    - `dout` <= the word at the read pointer.
    - The read pointer advances.
    - `count` <= `count` + 1.
  - Otherwise `ack` <= 0 and `dout` holds its value.
- Level update:
  - Write only: +1.
  - Pop only: -1.
  - Write and pop on the same edge: unchanged.
- The pop decision uses `level` from before the edge. A word written at edge k is not poppable before edge k+1.
- Full FIFO: `wr_ready`=0 even if a pop happens on the same edge. No bypass.
- `dout` holds the last delivered word between acks. This is required because the graph samples `din` on the rising edge of `ack`.
- `count` and `stall_count` wrap modulo 2^32.
- Reset clears everything:
  - Pointers = 0, `level` = 0, `ack` = 0, `dout` = 0, `count` = 0, `stall_count` = 0.
  - `wr_ready` = 1 after reset.
  - Stored data is discarded.
  - A reset asserted in the cycle after an ack drops `ack` at that edge; the word is considered delivered.
- No state machine beyond the `ack` flag. The ~`ack` guard prevents a second pop while the initiator's `req` is still high during the ack cycle.

## Timing
- Handshake sequence:
  - Edge k: `req`=1 and FIFO non-empty seen; `ack` and `dout` are valid after edge k.
  - Edge k+1: `ack` returns to 0. The initiator deasserts `req` on this same edge.
- Minimum spacing is one transfer per 2 cycles.
- Write-to-ack latency on an empty FIFO with `req` held high is 1 edge: written at edge k, acked at edge k+1.
- `wr_ready` reflects `level` in the same cycle, with zero latency.
- `req` may stay high arbitrarily long on an empty FIFO. `ack` stays 0 and nothing is popped.

## Configuration
- Macro `DATAFLOW_SRC_STALL_CNT_EN`.
- Defined:
  - `stall_count` increments on every edge where `req`=1, `ack`=0, `level`=0 and not in reset.
  - It is cleared by reset.
- Undefined:
  - `stall_count` is tied to constant 0 and no counter register is built.
  - All other behaviour is identical.

## Test plan
- Reset, then hold `rst`=0 for 2 cycles -> `ack`=0, `dout`=0, `count`=0, `level`=0, `wr_ready`=1.
- Write 5, 6, 7 back-to-back, then hold `req`=1 and deassert it one cycle after each `ack`:
  - Three acks spaced 2 cycles apart, with `dout`=5, 6, 7.
  - Final `count`=3, `level`=0.
- depth_log2=2, write 4 words -> `wr_ready`=0 and `level`=4. A 5th `wr_valid` is ignored. After one pop, `wr_ready`=1.
- Simultaneous write and pop at `level`=2 -> `level` stays 2 and the FIFO order is preserved.
- Stall: `req`=1 for 10 cycles on an empty FIFO, then write 0xABCD:
  - With the macro defined: `stall_count`=10.
  - Next edge: `ack`=1 with `dout`=0xABCD.
- Assert reset one cycle after an `ack` with 3 words queued -> `level`=0, `count`=0, `ack`=0. The queued words are never delivered.
